// File: rtl/debounce_pkg.sv
// debounce_pkg: shared channel bundle type and counter sizing helper
// for the multi-channel debouncer.
package debounce_pkg;

   typedef struct packed {
      logic y;
      logic rise;
      logic fall;
      logic hold;
   } chan_t;

   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one channel -- synchroniser, mismatch filter, edge strobes.
// Long-press detector compiled in with DEBOUNCE_LONG_PRESS_EN.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int   TD_CYCLES   = 1000000,
   parameter int   SYNC_STAGES = 2,
   parameter logic INIT_LEVEL  = 1'b0
`ifdef DEBOUNCE_LONG_PRESS_EN
   ,
   parameter int   HOLD_CYCLES = 100000000
`endif
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  sample_en,
   input  logic  x,
   output chan_t st
);

   localparam int            CW      = cnt_w(TD_CYCLES);
   localparam logic [CW-1:0] TD_LAST = CW'(TD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   s;
   logic                   y;
   logic                   rise;
   logic                   fall;
   logic                   hold;
   logic                   accept;

   assign s      = sync[SYNC_STAGES-1];
   assign accept = (s != y) && sample_en && (cnt == TD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {SYNC_STAGES{INIT_LEVEL}};
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], x};
      end
   end

   // Strobes are registered alongside y so they line up with the new level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         y    <= INIT_LEVEL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= accept & s;
         fall <= accept & ~s;
         if (s == y) begin
            cnt <= '0;
         end else if (sample_en) begin
            if (cnt == TD_LAST) begin
               y   <= s;
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int            HW        = cnt_w(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);

   logic [HW-1:0] hcnt;

   // Parking one past the pulse value keeps it to a single pulse per press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt <= '0;
         hold <= 1'b0;
      end else begin
         hold <= y && sample_en && (hcnt == HOLD_LAST);
         if (!y) begin
            hcnt <= '0;
         end else if (sample_en && (hcnt != HOLD_SAT)) begin
            hcnt <= hcnt + 1'b1;
         end
      end
   end
`else
   assign hold = 1'b0;
`endif

   assign st = '{y: y, rise: rise, fall: fall, hold: hold};

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: NCH independent debounce channels sharing one sample tick.
// Define DEBOUNCE_LONG_PRESS_EN to add the per-channel long-press strobe.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int   NCH         = 4,
   parameter int   TD_CYCLES   = 1000000,
   parameter int   SYNC_STAGES = 2,
   parameter logic INIT_LEVEL  = 1'b0,
   parameter int   HOLD_CYCLES = 100000000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sample_en,
   input  logic [NCH-1:0] x,
   output logic [NCH-1:0] y,
   output logic [NCH-1:0] rise,
   output logic [NCH-1:0] fall,
   output logic [NCH-1:0] hold
);

   if (NCH < 1 || TD_CYCLES < 1 || SYNC_STAGES < 2 || HOLD_CYCLES < 1)
   begin : g_bad_param
      $error("debounce_bank: illegal parameter value");
   end

   chan_t st [NCH];

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      debounce_chan #(
         .TD_CYCLES   (TD_CYCLES),
         .SYNC_STAGES (SYNC_STAGES),
         .INIT_LEVEL  (INIT_LEVEL)
`ifdef DEBOUNCE_LONG_PRESS_EN
         ,
         .HOLD_CYCLES (HOLD_CYCLES)
`endif
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .sample_en (sample_en),
         .x         (x[i]),
         .st        (st[i])
      );

      assign y[i]    = st[i].y;
      assign rise[i] = st[i].rise;
      assign fall[i] = st[i].fall;
      assign hold[i] = st[i].hold;
   end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed stimulus, per-cycle model compare and
// hand-computed timing checks for debounce_bank.
module tb_debounce_bank;

   localparam int   NCH  = 4;
   localparam int   TD   = 4;
   localparam int   SYNC = 2;
   localparam logic INIT = 1'b0;
   localparam int   HOLD = 8;

   logic           clk       = 1'b0;
   logic           rst_n     = 1'b0;
   logic           sample_en = 1'b1;
   logic [NCH-1:0] x         = '0;
   logic [NCH-1:0] y;
   logic [NCH-1:0] rise;
   logic [NCH-1:0] fall;
   logic [NCH-1:0] hold;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   debounce_bank #(
      .NCH         (NCH),
      .TD_CYCLES   (TD),
      .SYNC_STAGES (SYNC),
      .INIT_LEVEL  (INIT),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .x         (x),
      .y         (y),
      .rise      (rise),
      .fall      (fall),
      .hold      (hold)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", n, got, exp, cyc);
      end
   endtask

   // Model: x reaches the filter SYNC edges later; a new level is taken
   // after TD consecutive enabled samples that disagree with it.
   logic [NCH-1:0] xq [$];
   logic [NCH-1:0] sv;
   logic [NCH-1:0] yp;
   logic [NCH-1:0] ey = {NCH{INIT}};
   logic [NCH-1:0] er = '0;
   logic [NCH-1:0] ef = '0;
   logic [NCH-1:0] eh = '0;
   int             run [NCH];
   int             hc  [NCH];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xq.delete();
         for (int i = 0; i < SYNC; i++) xq.push_back({NCH{INIT}});
         ey = {NCH{INIT}};
         er = '0;
         ef = '0;
         eh = '0;
         for (int c = 0; c < NCH; c++) begin
            run[c] = 0;
            hc[c]  = 0;
         end
      end else begin
         sv = xq.pop_front();
         xq.push_back(x);
         yp = ey;
         er = '0;
         ef = '0;
         eh = '0;
         for (int c = 0; c < NCH; c++) begin
            if (sv[c] == yp[c]) begin
               run[c] = 0;
            end else if (sample_en) begin
               run[c]++;
               if (run[c] == TD) begin
                  ey[c]  = sv[c];
                  run[c] = 0;
                  if (sv[c]) er[c] = 1'b1;
                  else       ef[c] = 1'b1;
               end
            end
`ifdef DEBOUNCE_LONG_PRESS_EN
            if (!yp[c]) begin
               hc[c] = 0;
            end else if (sample_en) begin
               hc[c]++;
               if (hc[c] == HOLD) eh[c] = 1'b1;
            end
`endif
         end
      end
   end

   always @(negedge clk) begin
      chk("model_y", y, ey);
      chk("model_rise", rise, er);
      chk("model_fall", fall, ef);
      chk("model_hold", hold, eh);
   end

   int rise_edge [NCH] = '{default: -1};
   int fall_edge [NCH] = '{default: -1};
   int hold_edge [NCH] = '{default: -1};
   int rise_cnt  [NCH] = '{default: 0};
   int fall_cnt  [NCH] = '{default: 0};
   int hold_cnt  [NCH] = '{default: 0};

   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (rise[c] === 1'b1) begin
            rise_edge[c] = cyc;
            rise_cnt[c]++;
         end
         if (fall[c] === 1'b1) begin
            fall_edge[c] = cyc;
            fall_cnt[c]++;
         end
         if (hold[c] === 1'b1) begin
            hold_edge[c] = cyc;
            hold_cnt[c]++;
         end
      end
   end

   task automatic to_edge(input int n);
      for (int i = 0; i < 1000 && cyc < n; i++) @(negedge clk);
   endtask

   int e;
   int r;
   int h0;

   initial begin
      @(negedge clk);
      chk("rst_y", y, 0);
      chk("rst_rise", rise, 0);
      chk("rst_fall", fall, 0);
      chk("rst_hold", hold, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // step on channel 0
      @(negedge clk);
      x[0] = 1'b1;
      e = cyc + 1;
      to_edge(e + 4);
      chk("t1_y_early", y[0], 0);
      to_edge(e + 5);
      chk("t1_y", y[0], 1);
      chk("t1_rise", rise[0], 1);
      chk("t1_others", y[3:1], 0);
      to_edge(e + 6);
      chk("t1_rise_1clk", rise[0], 0);
      x[0] = 1'b0;
      to_edge(cyc + 8);

      // 3-cycle glitch rejected, 4-cycle glitch accepted
      x[1] = 1'b1;
      repeat (3) @(negedge clk);
      x[1] = 1'b0;
      to_edge(cyc + 10);
      chk("t2_short_rise", rise_cnt[1], 0);
      chk("t2_short_fall", fall_cnt[1], 0);
      chk("t2_short_y", y[1], 0);
      x[1] = 1'b1;
      e = cyc + 1;
      repeat (4) @(negedge clk);
      x[1] = 1'b0;
      to_edge(cyc + 12);
      chk("t2_long_rise", rise_cnt[1], 1);
      chk("t2_long_rise_at", rise_edge[1] - e, 5);
      chk("t2_long_fall", fall_cnt[1], 1);
      chk("t2_fall_gap", fall_edge[1] - rise_edge[1], 4);

      // sample_en one in three
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         if (k == 0) begin
            x[2] = 1'b1;
            e = cyc + 1;
         end
         sample_en = (k % 3 == 0);
      end
      @(negedge clk);
      sample_en = 1'b1;
      chk("t3_rise_at", rise_edge[2] - e, 12);
      chk("t3_y", y[2], 1);

      // simultaneous channels
      x[0] = 1'b1;
      x[3] = 1'b1;
      e = cyc + 1;
      to_edge(cyc + 8);
      chk("t4_same_edge", rise_edge[0], rise_edge[3]);
      chk("t4_rise_at", rise_edge[0] - e, 5);
      x[0] = 1'b0;
      to_edge(cyc + 8);

      // async reset mid-count on channel 0
      x[0] = 1'b1;
      e = cyc + 1;
      to_edge(e + 3);
      chk("t5_pre_y", y, 4'b1100);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_y", y, 0);
      chk("t5_async_rise", rise, 0);
      chk("t5_async_fall", fall, 0);
      h0 = hold_cnt[0];
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      r = cyc + 1;
      to_edge(r + 4);
      chk("t5_y_early", y[0], 0);
      to_edge(r + 5);
      chk("t5_rise0", rise[0], 1);
      chk("t5_rise3", rise[3], 1);

      // long press
      to_edge(r + 30);
`ifdef DEBOUNCE_LONG_PRESS_EN
      chk("t6_hold_count", hold_cnt[0] - h0, 1);
      chk("t6_hold_at", hold_edge[0] - rise_edge[0], HOLD);
`else
      chk("t6_hold_count", hold_cnt[0] - h0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
